fir_mac_engine: RTL
===================

Name: fir_mac_engine

Overview:
- Parametrised multi-channel FIR sample processor built around one time-shared multiply-accumulate (MAC) unit.
- Accepts one signed sample per strobe on `data_ready`, convolves it with a runtime-loadable coefficient set, then rounds and saturates the result.
- Presents the result on `outp` with a one-cycle `out_valid` pulse.
- Successor to the fixed 8-bit single-channel sample core. Adds channel interleaving, coefficient loading, overrun detection and saturation.

Parameters:
- DATA_W, 8: input sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed.
- FRAC, 14: coefficient fractional bits (Q format); must satisfy FRAC <= COEF_W-2.
- TAPS, 16: filter length, >= 2.
- CH, 1: number of interleaved channels, >= 1.
- OUT_W, 8: output width, signed.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_ready  in  1  sample strobe; a sample is accepted on its rising edge.
- ch_sel  in  max(1,clog2(CH))  channel of the offered sample.
- inp  in  DATA_W  sample value.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  clog2(TAPS)  tap index.
- coef_data  in  COEF_W  coefficient value.
- overrun_clr  in  1  clears `overrun`.
- outp  out  OUT_W  filtered result; holds until the next result.
- out_valid  out  1  one-cycle pulse when `outp` updates.
- out_ch  out  max(1,clog2(CH))  channel of the current `outp`.
- busy  out  1  high from accept until `out_valid`, inclusive.
- overrun  out  1  sticky dropped-sample flag.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - All delay lines are cleared to 0 and the FSM goes to IDLE.
  - `outp`, `out_valid`, `out_ch`, `busy` and `overrun` all go to 0.
  - Coefficients reset to identity: c[0] = 2^FRAC, all others 0.
  - A reset mid-computation aborts it; no `out_valid` is produced.
- **Strobe detection:** `data_ready` is registered once. An edge is data_ready=1 while the previous-cycle value was 0. A strobe held high for any length produces exactly one accept.
- **Accept:** an edge while in IDLE captures `inp` and `ch_sel`; the FSM moves to SHIFT. `ch_sel` >= CH is treated as channel 0.
- **FSM:**
  - IDLE -> SHIFT on accept.
  - SHIFT, 1 cycle: the sample is written into the selected channel's circular delay line and that channel's write pointer advances, wrapping at TAPS.
  - MAC, TAPS cycles: k = 0..TAPS-1, acc += x[n-k]*c[k], both operands signed. acc is cleared in SHIFT.
  - ROUND, 1 cycle: adds 2^(FRAC-1), shifts right arithmetically by FRAC, then saturates to the signed OUT_W range.
  - OUT, 1 cycle: loads `outp` and `out_ch`, pulses `out_valid`, then returns to IDLE.
- **Latency:** `out_valid` is high exactly TAPS+3 cycles after the accept cycle; 19 cycles at the defaults.
- **Widths:**
  - product = DATA_W+COEF_W bits.
  - ACC_W = DATA_W+COEF_W+clog2(TAPS), so the accumulator never wraps.
- **Overrun:**
  - An edge detected while `busy`=1 is dropped: the delay line is untouched and `overrun` is set.
  - `overrun` stays set until `overrun_clr`=1 or reset.
  - If set and clear coincide, set wins.
- **Coefficient writes:**
  - With `coef_we`=1 and `busy`=0, c[coef_addr] is written at the clock edge.
  - Writes while `busy`=1 are ignored.
  - A write and an accept in the same cycle: the write completes first, and the computation uses the new value.
- **Channels:** the delay lines are independent per channel. The coefficients are shared by all channels.

Decomposition:
- Shared package `fir_pkg`:
  - FSM state encoding (IDLE, SHIFT, MAC, ROUND, OUT).
  - ACC_W and pointer-width calculation functions.
  - Saturate and round function.
- One sub-module, `fir_delay_line`:
  - CH×TAPS sample storage with a write pointer per channel.
  - Write port plus a tap-offset read port that returns x[n-k] for a given channel.
- Everything else stays in `fir_mac_engine`: FSM, MAC, coefficient registers and output stage.

Test Plan:
- **Identity and latency:** after reset, pulse `data_ready` with inp=37 -> `out_valid` exactly 19 cycles later with outp=37; with inp=-5 -> outp=-5.
- **Moving average:** write c[0..15]=1024, then feed 16 samples of 64 spaced 30 cycles apart -> outputs 4,8,12,...,64; a 17th sample of 64 -> 64.
- **Rounding and saturation:**
  - c[0]=8192: inp=3 -> 2, inp=-3 -> -1.
  - c[0]=32767: inp=100 -> 127, inp=-100 -> -128.
- **Strobe and overrun:**
  - `data_ready` held high for 3 cycles -> exactly one `out_valid`.
  - A second edge 5 cycles after the first -> overrun=1, only one `out_valid`, and the next accepted sample's result shows the dropped sample never entered the delay line.
  - `overrun_clr` -> overrun=0.
- **Multi-channel (CH=2, c[0]=0, c[1]=16384):** feed alternately ch0=10, ch1=-20, ch0=30, ch1=40 -> outputs (ch0,0), (ch1,0), (ch0,10), (ch1,-20).
- **Reset mid-MAC:** assert `rst` low 8 cycles after accept -> no `out_valid`, all outputs 0; the next sample of 50 with identity coefficients -> outp=50.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR MAC engine:
//   fir_state_t - sequencer states (IDLE, SHIFT, MAC, ROUND, OUT)
//   ptr_w       - index width for a table of n entries (never below 1 bit)
//   acc_w       - accumulator width that cannot wrap over all taps
//   round_sat   - round-half-up, arithmetic shift by frac, clamp to out_w
// ---------------------------------------------------------------------------
package fir_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_MAC,
      ST_ROUND,
      ST_OUT
   } fir_state_t;

   function automatic int ptr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Product width plus one growth bit per doubling of the tap count.
   function automatic int acc_w(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction

   // Works on a 64-bit signed carrier so one function serves every
   // parameterisation; the caller truncates the clamped value to out_w.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] a,
                                                   input int frac,
                                                   input int out_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = a;
      if (frac > 0) r = (a + (64'sd1 <<< (frac - 1))) >>> frac;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_delay_line.sv
// ---------------------------------------------------------------------------
// fir_delay_line
// CH independent circular sample histories of TAPS entries each.
//   clk, rst_n      - clock, async active-low reset (clears samples and ptrs)
//   wr_en/wr_ch     - push wr_data into channel wr_ch, advancing its pointer
//   rd_ch/rd_k      - combinational read of x[n-k] for channel rd_ch, where
//                     x[n] is the most recently pushed sample
// ---------------------------------------------------------------------------
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int TAPS   = 16,
   parameter int CH     = 1,
   localparam int CW    = ptr_w(CH),
   localparam int PW    = ptr_w(TAPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [CW-1:0]     wr_ch,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [CW-1:0]     rd_ch,
   input  logic [PW-1:0]     rd_k,
   output logic [DATA_W-1:0] rd_data
);

   logic [CH-1:0][TAPS-1:0][DATA_W-1:0] mem_q;
   logic [CH-1:0][PW-1:0]               wp_q;
   logic [PW:0]                         sum;
   logic [PW-1:0]                       idx;

   // The write pointer already points past x[n], so x[n-k] sits at
   // wp-1-k modulo TAPS. Adding TAPS first keeps the sum non-negative,
   // and one conditional subtract folds it back for any TAPS.
   always_comb begin
      sum = {1'b0, wp_q[rd_ch]} + (PW+1)'(TAPS - 1) - {1'b0, rd_k};
      idx = (sum >= (PW+1)'(TAPS)) ? PW'(sum - (PW+1)'(TAPS)) : PW'(sum);
   end

   assign rd_data = mem_q[rd_ch][idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wp_q  <= '0;
      end else if (wr_en) begin
         mem_q[wr_ch][wp_q[wr_ch]] <= wr_data;
         wp_q[wr_ch] <= (wp_q[wr_ch] == PW'(TAPS - 1)) ? '0 : wp_q[wr_ch] + 1'b1;
      end
   end

endmodule

// File: rtl/fir_mac_engine.sv
// ---------------------------------------------------------------------------
// fir_mac_engine
// Multi-channel FIR sample processor with one time-shared MAC.
//   CLOCK_50     - clock, rising edge
//   rst          - async active-low reset
//   data_ready   - sample strobe, accepted on its rising edge when idle
//   ch_sel, inp  - channel and signed sample captured on accept
//   coef_we/coef_addr/coef_data - coefficient write, honoured when idle
//   overrun_clr  - clears the sticky overrun flag (a new drop wins)
//   outp, out_ch - rounded/saturated result and its channel, held
//   out_valid    - one-cycle pulse when outp/out_ch update
//   busy         - high from the cycle after accept through out_valid
//   overrun      - sticky: a strobe edge arrived while busy and was dropped
// Sequence per sample: SHIFT (1) -> MAC (TAPS) -> ROUND (1) -> OUT (1);
// out_valid rises TAPS+3 cycles after the accept cycle.
// ---------------------------------------------------------------------------
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 16,
   parameter int FRAC   = 14,
   parameter int TAPS   = 16,
   parameter int CH     = 1,
   parameter int OUT_W  = 8,
   localparam int CW    = ptr_w(CH),
   localparam int PW    = ptr_w(TAPS)
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   input  logic              data_ready,
   input  logic [CW-1:0]     ch_sel,
   input  logic [DATA_W-1:0] inp,
   input  logic              coef_we,
   input  logic [PW-1:0]     coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   input  logic              overrun_clr,
   output logic [OUT_W-1:0]  outp,
   output logic              out_valid,
   output logic [CW-1:0]     out_ch,
   output logic              busy,
   output logic              overrun
);

   localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC;

   fir_state_t state_q, state_nxt;

   logic                     dr_q;
   logic                     strobe;
   logic                     accept;
   logic                     drop;
   logic [CW-1:0]            ch_in;
   logic signed [DATA_W-1:0] smp_q;
   logic [CW-1:0]            ch_q;
   logic [PW-1:0]            k_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [COEF_W-1:0] coef_q [TAPS];
   logic signed [DATA_W-1:0] tap_x;
   logic signed [PROD_W-1:0] prod;

   // Rising-edge detect against the registered strobe, so a held strobe
   // yields a single event.
   assign strobe = data_ready & ~dr_q;
   assign busy   = (state_q != ST_IDLE);
   assign accept = strobe & ~busy;
   assign drop   = strobe & busy;
   assign ch_in  = (int'(ch_sel) < CH) ? ch_sel : '0;

   // Operands widened to the full product width before multiplying so the
   // signed product is exact.
   assign prod = PROD_W'(tap_x) * PROD_W'(coef_q[k_q]);

   fir_delay_line #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS),
      .CH     (CH)
   ) u_dly (
      .clk     (CLOCK_50),
      .rst_n   (rst),
      .wr_en   (state_q == ST_SHIFT),
      .wr_ch   (ch_q),
      .wr_data (smp_q),
      .rd_ch   (ch_q),
      .rd_k    (k_q),
      .rd_data (tap_x)
   );

   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
         ST_SHIFT: state_nxt = ST_MAC;
         ST_MAC:   if (k_q == PW'(TAPS - 1)) state_nxt = ST_ROUND;
         ST_ROUND: state_nxt = ST_OUT;
         ST_OUT:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Datapath. The rounded result is registered at the end of ROUND so
   // that outp and out_valid are presented together during OUT.
   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         dr_q      <= 1'b0;
         smp_q     <= '0;
         ch_q      <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         outp      <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         dr_q      <= data_ready;
         out_valid <= 1'b0;
         if (accept) begin
            smp_q <= inp;
            ch_q  <= ch_in;
         end
         unique case (state_q)
            ST_SHIFT: begin
               acc_q <= '0;
               k_q   <= '0;
            end
            ST_MAC: begin
               acc_q <= acc_q + ACC_W'(prod);
               k_q   <= k_q + 1'b1;
            end
            ST_ROUND: begin
               outp      <= OUT_W'(round_sat(64'(acc_q), FRAC, OUT_W));
               out_ch    <= ch_q;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

   // Coefficients are frozen while a sample is in flight; a write landing
   // on the accept edge is therefore already in place for the MAC.
   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
         coef_q[0] <= COEF_ONE;
      end else if (coef_we && !busy) begin
         coef_q[coef_addr] <= coef_data;
      end
   end

endmodule
